// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
//   - state_t : FSM state encoding (idle, shifting a word)
//   - cnt_w   : bit-counter width needed for a given word length
package piso_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the serializer.
//   load       : upstream request to hand over din
//   din        : parallel word, sampled only on an accepting edge
//   ready      : serializer can take a word this cycle
//   sout       : serial data bit
//   sout_valid : sout carries a data bit
//   done       : pulse during the last bit of a word
// master = upstream word source, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output load, din,
    input  ready, sout, sout_valid, done
  );

  modport slave (
    input  load, din,
    output ready, sout, sout_valid, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register.
// Accepts a WIDTH-bit word when load=1 and ready=1, then drives it out one
// bit per clk on sout, head bit first (MSB or LSB per MSB_FIRST). A new word
// may be accepted during the last bit so words stream with no gap.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : piso_serializer_if.slave (load/din in; ready/sout/sout_valid/done out)
// sout, sout_valid and done are registered; ready decodes state/counter only.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 16,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] sreg_r, sreg_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             sout_r, sout_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             done_r, done_nxt_s;
  logic             ready_s;
  logic             accept_s;

  // Bit that goes out first from a word.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Word advanced one place toward the head, vacated end zero-filled.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Ready is a pure state/counter decode: idle, or on the last bit.
  assign ready_s  = (state_r == ST_IDLE) || (cnt_r == CNT_ZERO);
  assign accept_s = bus.load && ready_s;

  // Next-state and next-output decode.
  // The head bit is pulled out into sout_r when registered, so sreg_r only
  // holds the bits still to come.
  always_comb begin
    state_nxt_s = state_r;
    sreg_nxt_s  = sreg_r;
    cnt_nxt_s   = cnt_r;
    sout_nxt_s  = IDLE_LEVEL;
    valid_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SHIFT;
          sout_nxt_s  = head_bit(bus.din);
          sreg_nxt_s  = shift_word(bus.din);
          cnt_nxt_s   = CNT_LAST;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r != CNT_ZERO) begin
          sout_nxt_s  = head_bit(sreg_r);
          sreg_nxt_s  = shift_word(sreg_r);
          cnt_nxt_s   = cnt_r - CNT_ONE;
          valid_nxt_s = 1'b1;
          // Counter about to reach zero: next cycle carries the last bit.
          done_nxt_s  = (cnt_r == CNT_ONE);
        end else if (accept_s) begin
          // Back-to-back word: its first bit follows with no gap.
          state_nxt_s = ST_SHIFT;
          sout_nxt_s  = head_bit(bus.din);
          sreg_nxt_s  = shift_word(bus.din);
          cnt_nxt_s   = CNT_LAST;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          sreg_nxt_s  = '0;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        sreg_nxt_s  = '0;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sreg_r  <= '0;
      cnt_r   <= CNT_ZERO;
      sout_r  <= IDLE_LEVEL;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sreg_r  <= sreg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sout_r  <= sout_nxt_s;
      valid_r <= valid_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.ready      = ready_s;
  assign bus.sout       = sout_r;
  assign bus.sout_valid = valid_r;
  assign bus.done       = done_r;

endmodule
